// File: rtl/tdp_ram_pkg.sv
// tdp_ram_pkg: shared constants and types for the tdp_ram_clr block.
//   RDW_* : same-port read-during-write mode encodings
//   state_e : clear-engine FSM states
package tdp_ram_pkg;

  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;
  localparam int unsigned RDW_NO_CHANGE   = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

endpackage

// File: rtl/tdp_ram_port.sv
// tdp_ram_port: per-port access logic for tdp_ram_clr.
// Lane merge, read-during-write mux, out-of-range check and q/vld pipeline.
// Optional macro TDP_RAM_OUTREG_EN adds a second q/vld register stage.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   en_i            access enable (ce already gated by the clear engine)
//   addr_i, we_i    address, per-lane write enable
//   d_i             write data
//   rdata_i         current array word at addr_i (pre-write)
//   q_o, vld_o      registered read data and valid strobe
//   wr_c_o          in-range write accepted this cycle (combinational)
//   oob_c_o         out-of-range access this cycle (combinational)
module tdp_ram_port
  import tdp_ram_pkg::*;
#(
  parameter int unsigned DWIDTH   = 16,
  parameter int unsigned BWIDTH   = 8,
  parameter int unsigned AWIDTH   = 12,
  parameter int unsigned MEM_SIZE = 3840,
  parameter int unsigned RDW_MODE = RDW_READ_FIRST
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en_i,
  input  logic [AWIDTH-1:0]          addr_i,
  input  logic [DWIDTH/BWIDTH-1:0]   we_i,
  input  logic [DWIDTH-1:0]          d_i,
  input  logic [DWIDTH-1:0]          rdata_i,
  output logic [DWIDTH-1:0]          q_o,
  output logic                       vld_o,
  output logic                       wr_c_o,
  output logic                       oob_c_o
);

  localparam int unsigned NB = DWIDTH / BWIDTH;

  logic              in_rng;
  logic              is_wr;
  logic [DWIDTH-1:0] merged;
  logic [DWIDTH-1:0] q_d, q_q;
  logic              vld_d, vld_q;

  assign in_rng  = (32'(addr_i) < MEM_SIZE);
  assign is_wr   = |we_i;
  assign wr_c_o  = en_i & in_rng & is_wr;
  assign oob_c_o = en_i & ~in_rng;

  // Word as it will look after this port's lane writes
  always_comb begin
    merged = rdata_i;
    for (int i = 0; i < NB; i++) begin
      if (we_i[i]) merged[i*BWIDTH +: BWIDTH] = d_i[i*BWIDTH +: BWIDTH];
    end
  end

  // Read result select; q holds whenever no valid result is produced
  always_comb begin
    q_d   = q_q;
    vld_d = 1'b0;
    if (en_i) begin
      if (!in_rng) begin
        q_d   = '0;
        vld_d = 1'b1;
      end else if (!is_wr) begin
        q_d   = rdata_i;
        vld_d = 1'b1;
      end else if (RDW_MODE == RDW_WRITE_FIRST) begin
        q_d   = merged;
        vld_d = 1'b1;
      end else if (RDW_MODE != RDW_NO_CHANGE) begin
        q_d   = rdata_i;
        vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      vld_q <= vld_d;
    end
  end

`ifdef TDP_RAM_OUTREG_EN
  logic [DWIDTH-1:0] q2_q;
  logic              vld2_q;

  // Extra output stage for timing closure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q2_q   <= '0;
      vld2_q <= 1'b0;
    end else begin
      q2_q   <= q_q;
      vld2_q <= vld_q;
    end
  end

  assign q_o   = q2_q;
  assign vld_o = vld2_q;
`else
  assign q_o   = q_q;
  assign vld_o = vld_q;
`endif

endmodule

// File: rtl/tdp_ram_clr.sv
// tdp_ram_clr: true-dual-port RAM with byte lanes, collision detect,
// sticky out-of-range flag and a hardware clear engine.
// Optional macro TDP_RAM_OUTREG_EN: extra q/vld/coll/oob stage (latency 2).
// Ports:
//   clk, rst_n               clock, async active-low reset
//   clr_req / clr_busy       clear request pulse / clear in progress
//   addr0/1, ce0/1, we0/1    port address, enable, per-lane write enable
//   d0/1, q0/1, vld0/1       write data, read data, read valid
//   coll                     cross-port same-address collision pulse
//   oob                      sticky out-of-range access flag
module tdp_ram_clr
  import tdp_ram_pkg::*;
#(
  parameter int unsigned       DWIDTH    = 16,
  parameter int unsigned       BWIDTH    = 8,
  parameter int unsigned       AWIDTH    = 12,
  parameter int unsigned       MEM_SIZE  = 3840,
  parameter int unsigned       RDW_MODE  = RDW_READ_FIRST,
  parameter logic [DWIDTH-1:0] CLR_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_req,
  output logic                     clr_busy,
  input  logic [AWIDTH-1:0]        addr0,
  input  logic                     ce0,
  input  logic [DWIDTH/BWIDTH-1:0] we0,
  input  logic [DWIDTH-1:0]        d0,
  output logic [DWIDTH-1:0]        q0,
  output logic                     vld0,
  input  logic [AWIDTH-1:0]        addr1,
  input  logic                     ce1,
  input  logic [DWIDTH/BWIDTH-1:0] we1,
  input  logic [DWIDTH-1:0]        d1,
  output logic [DWIDTH-1:0]        q1,
  output logic                     vld1,
  output logic                     coll,
  output logic                     oob
);

  localparam int unsigned NB = DWIDTH / BWIDTH;
  localparam int unsigned CW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              clr_start;
  logic              en0, en1;
  logic              wr0, wr1;
  logic              oob_hit0, oob_hit1;
  logic              coll_hit;
  logic              coll_q, oob_q;
  logic [CW-1:0]     idx0, idx1;
  logic [DWIDTH-1:0] rdata0, rdata1;

  logic [DWIDTH-1:0] mem [MEM_SIZE];

  assign clr_busy  = (state_q == ST_CLEAR);
  assign clr_start = (state_q == ST_IDLE) & clr_req;
  assign en0       = ce0 & ~clr_busy;
  assign en1       = ce1 & ~clr_busy;
  assign idx0      = CW'(addr0);
  assign idx1      = CW'(addr1);
  // Pre-write word; out-of-range reads are replaced by 0 in the port
  assign rdata0    = mem[idx0];
  assign rdata1    = mem[idx1];
  assign coll_hit  = en0 & en1 & (addr0 == addr1) & ((|we0) | (|we1));

  // Clear engine next state: sweep 0..MEM_SIZE-1 then idle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (cnt_q == CW'(MEM_SIZE - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Control and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      coll_q  <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      coll_q  <= coll_hit;
      oob_q   <= clr_start ? 1'b0 : (oob_q | oob_hit0 | oob_hit1);
    end
  end

  // Array write; port 1 lanes are applied last so they win on overlap
  always_ff @(posedge clk) begin
    if (clr_busy) begin
      mem[cnt_q] <= CLR_VALUE;
    end else begin
      if (wr0) begin
        for (int i = 0; i < NB; i++) begin
          if (we0[i]) mem[idx0][i*BWIDTH +: BWIDTH] <= d0[i*BWIDTH +: BWIDTH];
        end
      end
      if (wr1) begin
        for (int i = 0; i < NB; i++) begin
          if (we1[i]) mem[idx1][i*BWIDTH +: BWIDTH] <= d1[i*BWIDTH +: BWIDTH];
        end
      end
    end
  end

  tdp_ram_port #(
    .DWIDTH  (DWIDTH),
    .BWIDTH  (BWIDTH),
    .AWIDTH  (AWIDTH),
    .MEM_SIZE(MEM_SIZE),
    .RDW_MODE(RDW_MODE)
  ) u_port0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en0),
    .addr_i (addr0),
    .we_i   (we0),
    .d_i    (d0),
    .rdata_i(rdata0),
    .q_o    (q0),
    .vld_o  (vld0),
    .wr_c_o (wr0),
    .oob_c_o(oob_hit0)
  );

  tdp_ram_port #(
    .DWIDTH  (DWIDTH),
    .BWIDTH  (BWIDTH),
    .AWIDTH  (AWIDTH),
    .MEM_SIZE(MEM_SIZE),
    .RDW_MODE(RDW_MODE)
  ) u_port1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en1),
    .addr_i (addr1),
    .we_i   (we1),
    .d_i    (d1),
    .rdata_i(rdata1),
    .q_o    (q1),
    .vld_o  (vld1),
    .wr_c_o (wr1),
    .oob_c_o(oob_hit1)
  );

`ifdef TDP_RAM_OUTREG_EN
  logic coll2_q, oob2_q;

  // Flag stage aligned with the extra q/vld stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll2_q <= 1'b0;
      oob2_q  <= 1'b0;
    end else begin
      coll2_q <= coll_q;
      oob2_q  <= oob_q;
    end
  end

  assign coll = coll2_q;
  assign oob  = oob2_q;
`else
  assign coll = coll_q;
  assign oob  = oob_q;
`endif

endmodule

// File: doc/tdp_ram_clr.md
# tdp_ram_clr

Parametrised true-dual-port block RAM for the preBuffer path: byte-lane write enables, a selectable read-during-write mode, registered cross-port collision detection and a hardware clear engine that zero-fills the array after reset or on request. Both ports serve the line/pre-buffer producers and consumers. Each port has a `vld` strobe, so downstream logic does not have to track read latency. An optional output register adds a read pipeline stage for timing closure.

## Interface
- DWIDTH, 16, data width; must be a multiple of BWIDTH
- BWIDTH, 8, byte-lane width; NB = DWIDTH/BWIDTH lanes
- AWIDTH, 12, address width
- MEM_SIZE, 3840, words; must be ≤ 2^AWIDTH
- RDW_MODE, 0, same-port read-during-write: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE
- CLR_VALUE, 0, word written by the clear engine
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clr_req  in  1  pulse; starts a full clear when the block is idle
- clr_busy  out  1  high while the clear runs
- addr0 / addr1  in  AWIDTH  port address
- ce0 / ce1  in  1  port enable
- we0 / we1  in  NB  per-lane write enable; all zero means read
- d0 / d1  in  DWIDTH  write data
- q0 / q1  out  DWIDTH  read data
- vld0 / vld1  out  1  q valid strobe
- coll  out  1  one-cycle collision pulse
- oob  out  1  sticky out-of-range access flag

## Operation
- FSM: CLEAR, IDLE.
  - Reset enters CLEAR with the counter at 0.
  - CLEAR writes CLR_VALUE at address = counter, one word per cycle, for MEM_SIZE cycles, then goes to IDLE.
  - In IDLE, clr_req=1 enters CLEAR with the counter at 0.
  - clr_req is ignored during CLEAR.
- During CLEAR, ce0/ce1 are ignored: no write, no read, vld low.
- Write: each lane i with we[i]=1 updates bits [i*BWIDTH +: BWIDTH]; the other lanes are unchanged.
- Read: ce=1 and we=0 → q = ram[addr].
- Same-port write with a read result, by RDW_MODE:
  - READ_FIRST: q = old word.
  - WRITE_FIRST: q = merged new word.
  - NO_CHANGE: q holds and vld stays low.
- q holds its last value whenever vld is low.
- Cross-port, same address, both ce:
  - One port writes, the other reads: the reader gets the old word.
  - Both write: port 1 wins on overlapping lanes; non-overlapping lanes from both ports land.
  - coll pulses in either case (both ports enabled, addresses equal, we0|we1 ≠ 0).
- Address ≥ MEM_SIZE with ce=1: write dropped, read returns 0 with vld asserted, oob set. oob clears only on reset or clr_req.
- The array has no reset; only control and output registers are reset.

## Timing
- Reset values:
  - q0 = q1 = 0
  - vld0 = vld1 = 0
  - coll = 0, oob = 0
  - clr_busy = 1 (asserted combinationally from the CLEAR state)
- Read latency L = 1 cycle (2 with the output register enabled), measured from the ce sample edge to q/vld.
- coll and oob are registered: they update L cycles after the access.
- Clear duration: clr_busy falls exactly MEM_SIZE cycles after reset release or after clr_req is sampled. The first normal access is accepted on the cycle clr_busy is low.
- rst_n asserted mid-clear restarts the clear from address 0. rst_n asserted mid-read flushes the vld pipeline.
- Full throughput: one access per port per cycle, no stalls.

## Configuration
- TDP_RAM_OUTREG_EN defined: an extra q/vld/coll/oob register stage; L = 2; the stage is reset to 0.
- TDP_RAM_OUTREG_EN undefined: L = 1.

## Structure
- Package tdp_ram_pkg holds:
  - RDW_MODE constants RDW_READ_FIRST / RDW_WRITE_FIRST / RDW_NO_CHANGE
  - the FSM state typedef (ST_CLEAR, ST_IDLE)
- Sub-module tdp_ram_port, instantiated twice. It contains the per-port lane-merge, RDW mux, OOB check and output/vld pipeline.
- The shared array and the cross-port priority stay in the top level.

## Test plan
- Reset release → clr_busy high for exactly 3840 cycles, then reads of addresses 0, 1919 and 3839 return 0x0000 with vld0 high L cycles after ce.
- Write 0xABCD to address 5 with we0=2'b11, then write with we0=2'b01 and d0=0x0012 → read returns 0xAB12.
- Same-port write 0x1111 over 0x2222 at address 7 → q0 = 0x2222 (READ_FIRST), 0x1111 (WRITE_FIRST), or q0 held with vld0=0 (NO_CHANGE).
- Same-cycle collision at address 9:
  - Port 0 writes 0x00FF with we=2'b11, port 1 writes 0x5500 with we=2'b10 → word = 0x55FF, coll pulses once.
  - Port 0 reads while port 1 writes → port 0 gets the old word, coll pulses.
- Read address 3840 → q = 0, vld high, oob set and sticky until clr_req. Write to address 4000 → no array change.
- Assert rst_n low at clear cycle 100 → after release, clr_busy lasts a full 3840 cycles. clr_req during CLEAR has no effect on the duration.
